mcycle_ctrl: RTL and testbench

//   Sequenced multi-cycle unit (MCycle) for the pipelined core: unsigned multiply and divide,
//   one iteration per cycle. Sits beside the execute stage.

---
 rtl/mcycle_pkg.sv | 22 ++
 rtl/mcycle_step.sv | 34 +++
 rtl/mcycle_ctrl.sv | 138 +++++++++++++
 tb/tb_mcycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
package mcycle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic MCYCLE_MUL = 1'b0;
  localparam logic MCYCLE_DIV = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcycle_step.sv
// One combinational iteration: shift-add multiply or restoring-divide trial subtract.
module mcycle_step
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 op,
  input  logic [WIDTH-1:0]     opnd,
  input  logic [2*WIDTH-1:0]   work_i,
  output logic [2*WIDTH-1:0]   work_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  assign unused_trial_bit = trial[WIDTH];

  always_comb begin
    sum    = {1'b0, work_i[2*WIDTH-1:WIDTH]} + (work_i[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // The bit shifted out of the remainder must take part in the trial subtract.
    rem_sh = work_i[2*WIDTH-1:WIDTH-1];
    trial  = {1'b0, rem_sh} - {2'b00, opnd};
    if (op == MCYCLE_MUL) begin
      work_o = {sum, work_i[WIDTH-1:1]};
    end else if (!trial[WIDTH+1]) begin
      work_o = {trial[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
    end else begin
      work_o = {rem_sh[WIDTH-1:0], work_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multi-cycle unsigned mul/div sequencer with Busy/Done/WA3R hazard handshake.
// MCYCLE_EARLY_TERM_EN: multiply finishes once the remaining multiplier bits are zero.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3,
  input  logic             Abort,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       WA3R,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [3:0]           wa3r_q, wa3r_d;
  logic [WIDTH-1:0]     res1_q, res1_d;
  logic [WIDTH-1:0]     res2_q, res2_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   step_nxt;
  logic                 finish;
  logic [2*WIDTH-1:0]   fin_work;

  mcycle_step #(.WIDTH(WIDTH)) u_step (
    .op     (op_q),
    .opnd   (opnd_q),
    .work_i (work_q),
    .work_o (step_nxt)
  );

`ifdef MCYCLE_EARLY_TERM_EN
  logic [WIDTH-1:0] left_mask;
  logic             mul_early;

  always_comb begin
    left_mask = {WIDTH{1'b1}} >> (WIDTH'(cnt_q) + WIDTH'(1));
    mul_early = (op_q == MCYCLE_MUL) && ((step_nxt[WIDTH-1:0] & left_mask) == '0);
    finish    = (cnt_q == LAST) || mul_early;
    // Shift is zero on the final iteration, so divide results pass through untouched.
    fin_work  = step_nxt >> (LAST - cnt_q);
  end
`else
  always_comb begin
    finish   = (cnt_q == LAST);
    fin_work = step_nxt;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    wa3r_d  = wa3r_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          state_d = ST_COMPUTE;
          cnt_d   = '0;
          op_d    = MCycleOp;
          wa3r_d  = WA3;
          opnd_d  = (MCycleOp == MCYCLE_MUL) ? Operand1 : Operand2;
          work_d  = {{WIDTH{1'b0}}, (MCycleOp == MCYCLE_MUL) ? Operand2 : Operand1};
        end
      end
      ST_COMPUTE: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          work_d = step_nxt;
          cnt_d  = cnt_q + 1'b1;
          if (finish) begin
            state_d = ST_DONE;
            res1_d  = fin_work[WIDTH-1:0];
            res2_d  = fin_work[2*WIDTH-1:WIDTH];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COMPUTE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MCYCLE_MUL;
      opnd_q  <= '0;
      work_q  <= '0;
      wa3r_q  <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      wa3r_q  <= wa3r_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign WA3R    = wa3r_q;
  assign Result1 = res1_q;
  assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Scoreboard bench for mcycle_ctrl: stimulus pushes model results, a monitor checks each Done.
module tb_mcycle_ctrl;

  localparam int W = 32;

  logic         CLK, RESETn, Start, MCycleOp, Abort;
  logic [W-1:0] Operand1, Operand2, Result1, Result2;
  logic [3:0]   WA3, WA3R;
  logic         Busy, Done;

  typedef struct {
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    logic [3:0]   wa3;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  logic [W-1:0] last_r1 = '0;
  logic [W-1:0] last_r2 = '0;

  mcycle_ctrl #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .WA3      (WA3),
    .Abort    (Abort),
    .Busy     (Busy),
    .Done     (Done),
    .WA3R     (WA3R),
    .Result1  (Result1),
    .Result2  (Result2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the operands; latency from the multiplier's top set bit.
  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] w, input int s);
    exp_t        e;
    logic [63:0] p;
    int          lat;
    lat = W + 1;
    if (op == 1'b0) begin
      p    = 64'(a) * 64'(b);
      e.r1 = p[31:0];
      e.r2 = p[63:32];
`ifdef MCYCLE_EARLY_TERM_EN
      lat = 2;
      for (int i = 0; i < W; i++) if (b[i]) lat = i + 2;
`endif
    end else if (b == 0) begin
      e.r1 = '1;
      e.r2 = a;
    end else begin
      e.r1 = a / b;
      e.r2 = a % b;
    end
    e.wa3 = w;
    e.cyc = s + lat;
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] w, input bit expect_done);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    WA3      = w;
    if (expect_done) sb.push_back(model(op, a, b, w, cyc));
    tick();
    Start    = 1'b0;
    MCycleOp = 1'($urandom);
    Operand1 = $urandom;
    Operand2 = $urandom;
    WA3      = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy !== 1'b0 || Done !== 1'b0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: Busy=%0b Done=%0b after %0d cycles, required idle", Busy, Done, n);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(Busy), 64'(0));
    chk({tag, "_done"}, 64'(Done), 64'(0));
    chk({tag, "_wa3r"}, 64'(WA3R), 64'(0));
    chk({tag, "_r1"}, 64'(Result1), 64'(0));
    chk({tag, "_r2"}, 64'(Result2), 64'(0));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESETn === 1'b1 && Done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: Done=1 at cycle %0d, required no completion pending", cyc);
        end else begin
          e = sb.pop_front();
          chk("result1", 64'(Result1), 64'(e.r1));
          chk("result2", 64'(Result2), 64'(e.r2));
          chk("wa3r", 64'(WA3R), 64'(e.wa3));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_at_done", 64'(Busy), 64'(0));
          last_r1 = e.r1;
          last_r2 = e.r2;
        end
      end
    end
  end

  initial begin : stim
    int           n;
    logic [W-1:0] a, b;
    logic         op;
    RESETn   = 1'b0;
    Start    = 1'b0;
    MCycleOp = 1'b0;
    Operand1 = '0;
    Operand2 = '0;
    WA3      = '0;
    Abort    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    RESETn = 1'b1;
    tick();
    chk_zero("post_reset");

    // Full-width multiply and latency window of Busy.
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b1);
    chk("busy_c1", 64'(Busy), 64'(1));
    chk("wa3r_c1", 64'(WA3R), 64'(5));
    repeat (31) tick();
    chk("busy_c32", 64'(Busy), 64'(1));
    wait_idle();

    issue(1'b1, 32'd100, 32'd7, 4'd2, 1'b1);
    wait_idle();
    issue(1'b1, 32'h1234_5678, 32'd0, 4'd6, 1'b1);
    wait_idle();

    // Start during a running op must be ignored.
    issue(1'b1, $urandom, $urandom | 32'h1, 4'd3, 1'b1);
    repeat (9) tick();
    Start    = 1'b1;
    WA3      = 4'd9;
    MCycleOp = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    tick();
    Start = 1'b0;
    chk("wa3r_hold", 64'(WA3R), 64'(3));
    wait_idle();

    // Abort at cycle 12, restart at cycle 14.
    issue(1'b0, $urandom, $urandom | 32'h8000_0000, 4'd7, 1'b0);
    repeat (11) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("busy_after_abort", 64'(Busy), 64'(0));
    chk("r1_after_abort", 64'(Result1), 64'(last_r1));
    chk("r2_after_abort", 64'(Result2), 64'(last_r2));
    tick();
    issue(1'b0, $urandom, $urandom, 4'd8, 1'b1);
    wait_idle();

    // Start with Abort in IDLE: nothing latched, no completion.
    Start    = 1'b1;
    Abort    = 1'b1;
    WA3      = 4'd12;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    tick();
    chk("start_abort_busy", 64'(Busy), 64'(0));
    chk("start_abort_wa3r", 64'(WA3R), 64'(8));

    // Asynchronous reset mid-divide.
    issue(1'b1, $urandom, $urandom | 32'h1, 4'd4, 1'b1);
    repeat (19) tick();
    RESETn = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    last_r1 = '0;
    last_r2 = '0;
    tick();
    RESETn = 1'b1;
    tick();
    issue(1'b1, $urandom, $urandom_range(1, 1000), 4'd10, 1'b1);
    wait_idle();

    issue(1'b0, 32'd5, 32'd3, 4'd11, 1'b1);
    wait_idle();
    issue(1'b0, $urandom, 32'd0, 4'd1, 1'b1);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      wait_idle();
      issue(op, a, b, 4'($urandom), 1'b1);
    end
    wait_idle();

    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
